// File: rtl/ps2_packet_rx.sv
// ps2_packet_rx: receives 4-frame PS2 packets (11-bit frames) from a
// raw, asynchronous PS2 clock/data pair and presents them as one packet.
//
// Ports:
//   i_clk          system clock (only clock of the block)
//   i_rst          asynchronous active-high reset
//   i_ps2_clk      raw PS2 clock line (asynchronous)
//   i_ps2_data     raw PS2 data line (asynchronous)
//   o_word1..4     frames of the last complete packet, arrival order,
//                  laid out [10]=start [9:2]=D0..D7 [1]=parity [0]=stop
//   o_ready        one-cycle pulse when o_word1..4 update
//   o_timeout      one-cycle pulse when a partial packet is dropped
//   o_busy         high while a packet is partially received
module ps2_packet_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ps2_clk,
    input  logic        i_ps2_data,
    output logic [10:0] o_word1,
    output logic [10:0] o_word2,
    output logic [10:0] o_word3,
    output logic [10:0] o_word4,
    output logic        o_ready,
    output logic        o_timeout,
    output logic        o_busy
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RECV = 1'b1
    } state_t;

    // Two-flop synchronisers; idle PS2 lines are high.
    logic [1:0] clk_sync_q;
    logic [1:0] dat_sync_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[0], i_ps2_clk};
            dat_sync_q <= {dat_sync_q[0], i_ps2_data};
        end
    end

    logic clk_s;
    logic dat_s;

    assign clk_s = clk_sync_q[1];
    assign dat_s = dat_sync_q[1];

    // Glitch filter: the filtered level follows the synchronised clock
    // only after FILTER_LEN consecutive disagreeing samples.
    logic          fclk_q;
    logic          fclk_d;
    logic [FW-1:0] fcnt_q;
    logic [FW-1:0] fcnt_d;
    logic          fall;

    always_comb begin
        fclk_d = fclk_q;
        fcnt_d = '0;
        if (clk_s != fclk_q) begin
            if (fcnt_q == FLT_LAST) begin
                fclk_d = ~fclk_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    // Falling edge is seen in the same cycle the filter flips to 0.
    assign fall = fclk_q & ~fclk_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fclk_q <= 1'b1;
            fcnt_q <= '0;
        end else begin
            fclk_q <= fclk_d;
            fcnt_q <= fcnt_d;
        end
    end

    // Frame / packet assembly
    state_t        state_q;
    state_t        state_d;
    logic [3:0]    bit_q;
    logic [3:0]    bit_d;
    logic [1:0]    frame_q;
    logic [1:0]    frame_d;
    logic [10:0]   shift_q;
    logic [10:0]   shift_d;
    logic [10:0]   slot0_q;
    logic [10:0]   slot0_d;
    logic [10:0]   slot1_q;
    logic [10:0]   slot1_d;
    logic [10:0]   slot2_q;
    logic [10:0]   slot2_d;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic [10:0]   word1_q;
    logic [10:0]   word1_d;
    logic [10:0]   word2_q;
    logic [10:0]   word2_d;
    logic [10:0]   word3_q;
    logic [10:0]   word3_d;
    logic [10:0]   word4_q;
    logic [10:0]   word4_d;
    logic          ready_q;
    logic          ready_d;
    logic          timeout_q;
    logic          timeout_d;
    logic [10:0]   frame_new;

    // Value of the shift register once the current sample is in.
    assign frame_new = {shift_q[9:0], dat_s};

    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        frame_d   = frame_q;
        shift_d   = shift_q;
        slot0_d   = slot0_q;
        slot1_d   = slot1_q;
        slot2_d   = slot2_q;
        timer_d   = timer_q;
        word1_d   = word1_q;
        word2_d   = word2_q;
        word3_d   = word3_q;
        word4_d   = word4_q;
        ready_d   = 1'b0;
        timeout_d = 1'b0;

        // An edge wins over a timeout reached in the same cycle.
        if (fall) begin
            timer_d = '0;
            shift_d = frame_new;
            state_d = S_RECV;
            if (bit_q == 4'd10) begin
                bit_d = '0;
                unique case (frame_q)
                    2'd0: begin
                        slot0_d = frame_new;
                        frame_d = 2'd1;
                    end
                    2'd1: begin
                        slot1_d = frame_new;
                        frame_d = 2'd2;
                    end
                    2'd2: begin
                        slot2_d = frame_new;
                        frame_d = 2'd3;
                    end
                    default: begin
                        word1_d = slot0_q;
                        word2_d = slot1_q;
                        word3_d = slot2_q;
                        word4_d = frame_new;
                        ready_d = 1'b1;
                        frame_d = 2'd0;
                        state_d = S_IDLE;
                    end
                endcase
            end else begin
                bit_d = bit_q + 1'b1;
            end
        end else begin
            unique case (state_q)
                S_RECV: begin
                    if (timer_q == TMO_LAST) begin
                        bit_d     = '0;
                        frame_d   = '0;
                        shift_d   = '0;
                        timer_d   = '0;
                        timeout_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                default: begin
                    timer_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            bit_q     <= '0;
            frame_q   <= '0;
            shift_q   <= '0;
            slot0_q   <= '0;
            slot1_q   <= '0;
            slot2_q   <= '0;
            timer_q   <= '0;
            word1_q   <= '0;
            word2_q   <= '0;
            word3_q   <= '0;
            word4_q   <= '0;
            ready_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_q     <= bit_d;
            frame_q   <= frame_d;
            shift_q   <= shift_d;
            slot0_q   <= slot0_d;
            slot1_q   <= slot1_d;
            slot2_q   <= slot2_d;
            timer_q   <= timer_d;
            word1_q   <= word1_d;
            word2_q   <= word2_d;
            word3_q   <= word3_d;
            word4_q   <= word4_d;
            ready_q   <= ready_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_word1   = word1_q;
    assign o_word2   = word2_q;
    assign o_word3   = word3_q;
    assign o_word4   = word4_q;
    assign o_ready   = ready_q;
    assign o_timeout = timeout_q;
    assign o_busy    = (state_q == S_RECV);

endmodule

// File: tb/tb_ps2_packet_rx.sv
// tb_ps2_packet_rx: randomized PS2 packet stimulus against a frame-level
// reference model (byte -> 11-bit frame, 4 frames -> packet).
module tb_ps2_packet_rx;

    localparam int HP  = 40;
    localparam int FL  = 8;
    localparam int TMO = 600;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ps2c = 1'b1;
    logic        ps2d = 1'b1;
    logic [10:0] w1;
    logic [10:0] w2;
    logic [10:0] w3;
    logic [10:0] w4;
    logic        rdy;
    logic        tmo;
    logic        busy;

    int vectors = 0;
    int errors  = 0;
    int rdy_cnt = 0;
    int tmo_cnt = 0;
    int hold_err = 0;

    logic [43:0] capq[$];
    logic [43:0] prev_w;

    ps2_packet_rx #(
        .FILTER_LEN    (FL),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_ps2_clk (ps2c),
        .i_ps2_data(ps2d),
        .o_word1   (w1),
        .o_word2   (w2),
        .o_word3   (w3),
        .o_word4   (w4),
        .o_ready   (rdy),
        .o_timeout (tmo),
        .o_busy    (busy)
    );

    always #5 clk = ~clk;

    // Observe on the falling edge: record packets, pulses, word holds.
    always @(negedge clk) begin
        if (rdy) begin
            rdy_cnt++;
            capq.push_back({w1, w2, w3, w4});
        end
        if (tmo) tmo_cnt++;
        if (!rst && !rdy && ({w1, w2, w3, w4} !== prev_w)) hold_err++;
        prev_w = {w1, w2, w3, w4};
    end

    // Reference frame: start=0, D0..D7 from bit 9 down, odd parity, stop.
    function automatic logic [10:0] mk(input logic [7:0] b,
                                       input logic perr,
                                       input logic stop);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[7-i] = b[i];
        return {1'b0, r, (~^b) ^ perr, stop};
    endfunction

    function automatic logic [43:0] rand_pkt();
        return {mk(8'($urandom), 1'b0, 1'b1), mk(8'($urandom), 1'b0, 1'b1),
                mk(8'($urandom), 1'b0, 1'b1), mk(8'($urandom), 1'b0, 1'b1)};
    endfunction

    task automatic send_bit(input logic b, input bit glitch);
        ps2d = b;
        repeat (HP / 2) @(posedge clk);
        if (glitch) begin
            ps2c = 1'b0;
            repeat (4) @(posedge clk);
            ps2c = 1'b1;
        end
        repeat (HP / 2) @(posedge clk);
        ps2c = 1'b0;
        repeat (HP) @(posedge clk);
        ps2c = 1'b1;
    endtask

    task automatic send_frame(input logic [10:0] w, input int nbits,
                              input int glitch_at);
        for (int i = 0; i < nbits; i++) send_bit(w[10-i], i == glitch_at);
    endtask

    task automatic send_packet(input logic [43:0] p, input int glitch_at);
        for (int f = 0; f < 4; f++) send_frame(p[43-11*f -: 11], 11, glitch_at);
    endtask

    task automatic test_reset();
        repeat (5) @(posedge clk);
        #1;
        vectors++;
        if ({w1, w2, w3, w4} !== 44'd0) begin
            errors++;
            $display("FAIL reset_words: got %h want 0", {w1, w2, w3, w4});
        end
        vectors++;
        if ({rdy, tmo, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000", {rdy, tmo, busy});
        end
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        vectors++;
        if ({rdy, tmo, busy} !== 3'b000) begin
            errors++;
            $display("FAIL post_reset_flags: got %b want 000", {rdy, tmo, busy});
        end
    endtask

    task automatic test_basic();
        logic [43:0] exp;
        int c0;
        exp = {mk(8'h08, 1'b0, 1'b1), mk(8'h01, 1'b0, 1'b1),
               mk(8'hFF, 1'b0, 1'b1), mk(8'h00, 1'b0, 1'b1)};
        c0 = rdy_cnt;
        capq.delete();
        send_packet(exp, -1);
        repeat (HP) @(posedge clk);
        #1;
        vectors++;
        if (rdy_cnt - c0 !== 1) begin
            errors++;
            $display("FAIL basic_ready_count: got %0d want 1", rdy_cnt - c0);
        end
        vectors++;
        if (w1 !== 11'b0_00010000_0_1) begin
            errors++;
            $display("FAIL basic_word1: got %b want 00001000001", w1);
        end
        vectors++;
        if (w4 !== 11'b0_00000000_1_1) begin
            errors++;
            $display("FAIL basic_word4: got %b want 00000000011", w4);
        end
        vectors++;
        if ({w1, w2, w3, w4} !== exp) begin
            errors++;
            $display("FAIL basic_words: got %h want %h", {w1, w2, w3, w4}, exp);
        end
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_random();
        logic [43:0] exp;
        for (int n = 0; n < 4; n++) begin
            exp = rand_pkt();
            capq.delete();
            send_packet(exp, -1);
            repeat (HP) @(posedge clk);
            #1;
            vectors++;
            if (capq.size() !== 1) begin
                errors++;
                $display("FAIL random_count[%0d]: got %0d want 1", n, capq.size());
            end else if (capq[0] !== exp) begin
                errors++;
                $display("FAIL random_pkt[%0d]: got %h want %h", n, capq[0], exp);
            end
        end
    endtask

    task automatic test_timeout();
        logic [43:0] keep;
        logic [43:0] exp;
        int c0;
        int t0;
        keep = {w1, w2, w3, w4};
        c0 = rdy_cnt;
        t0 = tmo_cnt;
        exp = rand_pkt();
        for (int f = 0; f < 3; f++) send_frame(exp[43-11*f -: 11], 11, -1);
        #1;
        vectors++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_busy_mid: got %b want 1", busy);
        end
        repeat (TMO + 300) @(posedge clk);
        #1;
        vectors++;
        if (tmo_cnt - t0 !== 1) begin
            errors++;
            $display("FAIL timeout_pulses: got %0d want 1", tmo_cnt - t0);
        end
        vectors++;
        if (rdy_cnt !== c0) begin
            errors++;
            $display("FAIL timeout_ready: got %0d want %0d", rdy_cnt, c0);
        end
        vectors++;
        if ({w1, w2, w3, w4} !== keep || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_hold: got %h/%b want %h/0",
                     {w1, w2, w3, w4}, busy, keep);
        end
        exp = rand_pkt();
        send_packet(exp, -1);
        repeat (HP) @(posedge clk);
        #1;
        vectors++;
        if ({w1, w2, w3, w4} !== exp || rdy_cnt - c0 !== 1) begin
            errors++;
            $display("FAIL timeout_next_pkt: got %h (%0d) want %h (1)",
                     {w1, w2, w3, w4}, rdy_cnt - c0, exp);
        end
    endtask

    task automatic test_glitch();
        logic [43:0] exp;
        int c0;
        c0 = rdy_cnt;
        ps2c = 1'b0;
        repeat (4) @(posedge clk);
        ps2c = 1'b1;
        repeat (HP) @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_idle_busy: got %b want 0", busy);
        end
        exp = rand_pkt();
        send_packet(exp, int'($urandom_range(0, 10)));
        repeat (HP) @(posedge clk);
        #1;
        vectors++;
        if ({w1, w2, w3, w4} !== exp || rdy_cnt - c0 !== 1) begin
            errors++;
            $display("FAIL glitch_pkt: got %h (%0d) want %h (1)",
                     {w1, w2, w3, w4}, rdy_cnt - c0, exp);
        end
    endtask

    task automatic test_reset_mid();
        logic [43:0] exp;
        int c0;
        exp = rand_pkt();
        send_frame(exp[43:33], 11, -1);
        send_frame(exp[32:22], 6, -1);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (busy !== 1'b0 || {w1, w2, w3, w4} !== 44'd0) begin
            errors++;
            $display("FAIL rst_mid_clear: got busy=%b w=%h want 0/0",
                     busy, {w1, w2, w3, w4});
        end
        repeat (3) @(posedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        c0 = rdy_cnt;
        exp = rand_pkt();
        send_packet(exp, -1);
        repeat (HP) @(posedge clk);
        #1;
        vectors++;
        if ({w1, w2, w3, w4} !== exp || rdy_cnt - c0 !== 1) begin
            errors++;
            $display("FAIL rst_mid_pkt: got %h (%0d) want %h (1)",
                     {w1, w2, w3, w4}, rdy_cnt - c0, exp);
        end
    endtask

    task automatic test_bad_frame();
        logic [43:0] exp;
        exp = {mk(8'($urandom), 1'b0, 1'b1), mk(8'($urandom), 1'b1, 1'b0),
               mk(8'($urandom), 1'b0, 1'b1), mk(8'($urandom), 1'b1, 1'b0)};
        exp[43] = 1'b1;
        capq.delete();
        send_packet(exp, -1);
        repeat (HP) @(posedge clk);
        #1;
        vectors++;
        if (capq.size() !== 1) begin
            errors++;
            $display("FAIL bad_frame_count: got %0d want 1", capq.size());
        end else if (capq[0] !== exp) begin
            errors++;
            $display("FAIL bad_frame_pkt: got %h want %h", capq[0], exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [43:0] e1;
        logic [43:0] e2;
        e1 = rand_pkt();
        e2 = rand_pkt();
        capq.delete();
        send_packet(e1, -1);
        send_packet(e2, -1);
        repeat (HP) @(posedge clk);
        #1;
        vectors++;
        if (capq.size() !== 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d want 2", capq.size());
        end else begin
            vectors++;
            if (capq[0] !== e1) begin
                errors++;
                $display("FAIL b2b_first: got %h want %h", capq[0], e1);
            end
            vectors++;
            if (capq[1] !== e2) begin
                errors++;
                $display("FAIL b2b_second: got %h want %h", capq[1], e2);
            end
        end
        vectors++;
        if ({w1, w2, w3, w4} !== e2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_final: got %h/%b want %h/0",
                     {w1, w2, w3, w4}, busy, e2);
        end
    endtask

    task automatic test_hold();
        vectors++;
        if (hold_err !== 0) begin
            errors++;
            $display("FAIL word_hold: got %0d changes want 0", hold_err);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_timeout();
        test_glitch();
        test_reset_mid();
        test_bad_frame();
        test_back_to_back();
        test_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/ps2_packet_rx.md
PS2_PACKET_RX -- requirements
Module: ps2_packet_rx

Interface
REQ-001 SHALL provide parameter FILTER_LEN, default 8: consecutive identical samples required before the filtered PS2 clock changes level.
REQ-002 SHALL provide parameter TIMEOUT_CYCLES, default 20000: idle cycles that abort a partial packet (200 us at 100 MHz).
REQ-003 SHALL have port i_clk, input, 1 bit: system clock; the block's only clock.
REQ-004 SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port i_ps2_clk, input, 1 bit: raw PS2 clock line, asynchronous to i_clk.
REQ-006 SHALL have port i_ps2_data, input, 1 bit: raw PS2 data line, asynchronous to i_clk.
REQ-007 SHALL have ports o_word1..o_word4, output, 11 bits each: the four frames of the last complete packet, in arrival order.
REQ-008 SHALL have port o_ready, output, 1 bit: one-cycle pulse when o_word1..4 update.
REQ-009 SHALL have port o_timeout, output, 1 bit: one-cycle pulse when a partial packet is discarded.
REQ-010 SHALL have port o_busy, output, 1 bit: high while a packet is partially received.

Function
REQ-011 SHALL synchronise i_ps2_clk and i_ps2_data through two flip-flops each before any use.
REQ-012 SHALL change the filtered clock level only after FILTER_LEN consecutive cycles of a synchronised clock value that differs from it; the filter counter resets on any mismatch.
REQ-013 SHALL detect a falling edge when the filtered clock goes 1->0, and sample synchronised data in that same cycle.
REQ-014 SHALL shift each sample in at bit 0 of an 11-bit shift register, so a completed frame has [10]=start, [9]=D0 ... [2]=D7, [1]=parity, [0]=stop.
REQ-015 SHALL count bits 0..10 per frame and frames 0..3 per packet; after the 11th bit, copy the frame to internal slot[frame index], clear the bit count, and increment the frame index.
REQ-016 SHALL, on the 11th bit of frame 4, load o_word1..o_word4 together and assert o_ready for exactly one cycle, starting the cycle after the falling-edge detect.
REQ-017 SHALL hold o_word1..o_word4 unchanged between o_ready pulses.
REQ-018 SHALL not check start, parity or stop bits; frame validation is done downstream.
REQ-019 SHALL use states IDLE (counts zero) and RECV (at least one bit received).
REQ-020 SHALL transition IDLE->RECV on the first falling edge, and RECV->IDLE on packet completion or on timeout.
REQ-021 SHALL, in RECV, count cycles since the last falling edge; on reaching TIMEOUT_CYCLES, clear the bit, frame and shift registers, pulse o_timeout for one cycle, enter IDLE, and leave outputs untouched.
REQ-022 SHALL give a falling edge precedence when it coincides with the timeout count being reached; the edge is accepted and the timer cleared.
REQ-023 SHALL drive o_busy high exactly in RECV.
REQ-024 SHALL treat filtered-clock rising edges as no-ops.

Reset
REQ-025 SHALL, on i_rst high, immediately clear o_word1..4, slots, shift register, counters and timer to 0, deassert o_ready, o_timeout and o_busy, set synchronisers and the filtered clock to 1, and enter IDLE.
REQ-026 SHALL discard any partial packet when reset is asserted mid-packet; the first edge after release is bit 0 of frame 1.

Verification
REQ-027 SHALL pass: reset, send bytes 0x08, 0x01, 0xFF, 0x00 with odd parity at 12.5 kHz PS2 clock -> one o_ready pulse; o_word1=11'b0_00010000_0_1, o_word4=11'b0_00000000_1_1; o_busy low afterwards.
REQ-028 SHALL pass: three frames sent, then 250 us idle -> o_timeout pulses once; o_ready never asserts; o_word* keep previous values; the next four frames form a correct packet.
REQ-029 SHALL pass: a 4-cycle low glitch on i_ps2_clk with FILTER_LEN=8 -> no bit counted; the bit count stays unchanged.
REQ-030 SHALL pass: i_rst pulsed after frame 2 bit 5 -> o_busy goes low immediately; a complete packet sent afterwards is captured correctly.
REQ-031 SHALL pass: a frame with a wrong parity bit and stop=0 -> captured verbatim in o_word* with o_ready pulse.
REQ-032 SHALL pass: two back-to-back packets with no gap -> two o_ready pulses; the second packet's words replace the first.
